ps2_keyboard_receiver: RTL and testbench
========================================

Name: ps2_keyboard_receiver

Overview:
PS/2 keyboard receiver that deserialises scan-code frames from the external keyboard and buffers them in a small FIFO. It sits directly upstream of the processor's input-selection multiplexer and drives its 8-bit keyboard-data input. The processor consumes bytes through a one-cycle read-pop handshake issued by the input instruction.

Parameters:
FIFO_DEPTH, 4, scan-code buffer entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 50000, system-clock cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
clock  input  1  system clock; all state on the rising edge.
reset  input  1  asynchronous, active-low reset.
ps2_clk  input  1  raw PS/2 clock line, asynchronous to clock.
ps2_data  input  1  raw PS/2 data line, asynchronous to clock.
rd_en  input  1  pops the FIFO head when high for one cycle.
clear_overflow  input  1  clears the sticky overflow flag.
key_data  output  8  FIFO head byte; 0 when empty; feeds the multiplexer keyboard input.
key_valid  output  1  high while the FIFO is non-empty.
overflow  output  1  sticky; a byte was dropped because the FIFO was full.
frame_error  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; bit count, shift register and timeout counter=0; FIFO empty; key_data=0, key_valid=0, overflow=0, frame_error=0. Reset asserted mid-frame discards the partial frame.
- Input conditioning: ps2_clk and ps2_data each pass through 2 synchronizer flops. A falling edge is detected when the previous synced ps2_clk=1 and the current synced ps2_clk=0. ps2_data is sampled only on that cycle.
- FSM:
  - IDLE: on an edge, data=0 (start bit) goes to DATA with count=0. Data=1 is ignored and the FSM stays in IDLE.
  - DATA: on each edge, shift in LSB first. After 8 bits, go to PARITY.
  - PARITY: on an edge, capture the parity bit and go to STOP.
  - STOP: on an edge, return to IDLE. The frame is good if stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity). A good frame is pushed; a bad frame pulses frame_error and is not pushed.
- Timeout: the counter clears on every edge and in IDLE. In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_error.
- Latency: the STOP edge is detected in cycle N; the byte is visible on key_data with key_valid=1 in cycle N+1.
- FIFO (first-word-fall-through):
  - key_data always shows the head entry.
  - rd_en while empty is ignored.
  - A push while full drops the byte and sets overflow.
  - A simultaneous push and pop while full succeeds with no overflow.
  - A simultaneous push and pop while empty pushes; the rd_en is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- Overflow: clear_overflow=1 clears the flag. If clear_overflow and a new overflow occur in the same cycle, the set wins.

Optional Feature:
PS2_BREAK_FILTER_EN
- Defined: the byte 0xF0 is not pushed and arms a drop flag. The next good byte (the released key) is also discarded, then the flag clears. Only make codes reach the FIFO. A frame error or reset clears the flag.
- Undefined: every good byte, including 0xF0, is pushed.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Constants: PS2_BREAK_CODE=8'hF0, PS2_DATA_BITS=8.
- One natural sub-module, keyboard_fifo: parameterised FWFT FIFO with push, pop, full, empty, count and head outputs. It is instantiated once; synchronisation, edge detection and the FSM stay in the top level.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), ps2_clk period 1000 cycles → key_valid=1 and key_data=0x1C one cycle after the stop edge. Then pulse rd_en → key_valid=0, key_data=0.
- 0x1C sent with parity=1 → frame_error pulses once, key_valid stays 0. A following good 0x32 is received correctly.
- FIFO_DEPTH=4, frames 0x11, 0x22, 0x33, 0x44, 0x55 with no reads:
  - overflow=1 after the fifth frame;
  - four pops return 0x11, 0x22, 0x33, 0x44;
  - clear_overflow → overflow=0.
- Stop edges after 5 data bits, wait TIMEOUT_CYCLES → frame_error pulse, FSM back in IDLE. A subsequent 0x1C is received intact.
- Frames 0xF0, 0x1C, 0x1B:
  - with PS2_BREAK_FILTER_EN, only 0x1B is queued;
  - without it, 0xF0, 0x1C and 0x1B are queued in order.
- Assert reset for 3 cycles after 4 data bits, with the FIFO holding one byte → all outputs 0 immediately (asynchronously). The next full frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

  // PS/2 frames use odd parity over the eight data bits plus the parity bit.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_if.sv
// Signal bundle between the PS/2 receiver (slave) and its environment (master).
interface ps2_keyboard_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       clear_overflow;
  logic [7:0] key_data;
  logic       key_valid;
  logic       overflow;
  logic       frame_error;

  // Read handshake: key_valid high means key_data holds the FIFO head; a byte
  // is consumed on each rising clock edge where rd_en and key_valid are both
  // high. rd_en with key_valid low has no effect.
  modport master (
    output ps2_clk, ps2_data, rd_en, clear_overflow,
    input  key_data, key_valid, overflow, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data, rd_en, clear_overflow,
    output key_data, key_valid, overflow, frame_error
  );
endinterface

// File: rtl/keyboard_fifo.sv
// First-word-fall-through FIFO for received scan codes; DEPTH must be a power of 2.
module keyboard_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rdPtr];

  // A pop frees a slot in the same cycle, so push-while-full succeeds when popping.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 scan-code receiver with FWFT buffer. Define PS2_BREAK_FILTER_EN to drop
// break codes (0xF0) and the released-key byte that follows them.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  ps2_keyboard_receiver_if.slave   kbd,
  output ps2State_t                fsmState
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    clkSync, dataSync;
  logic          clkPrev, fallEdge, dataBit;
  ps2State_t     state, stateNext;
  logic [2:0]    bitCount;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic [TW-1:0] timeoutCnt;
  logic          timeoutHit, frameDone, frameGood, frameBad, pushEn;
  logic          frameError, overflowReg, overflowSet;
  logic          fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [7:0]    fifoHead;
`ifdef PS2_BREAK_FILTER_EN
  logic          dropFlag, isBreak;
`endif

  // Lines idle high, so synchronizers reset to 1 to avoid a false first edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], kbd.ps2_clk};
      dataSync <= {dataSync[0], kbd.ps2_data};
      clkPrev  <= clkSync[1];
    end
  end

  assign fallEdge   = clkPrev & ~clkSync[1];
  assign dataBit    = dataSync[1];
  assign timeoutHit = (state != IDLE) && !fallEdge && (timeoutCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (timeoutHit) begin
      stateNext = IDLE;
    end else if (fallEdge) begin
      case (state)
        IDLE:    if (!dataBit) stateNext = DATA;
        DATA:    if (bitCount == 3'(PS2_DATA_BITS - 1)) stateNext = PARITY;
        PARITY:  stateNext = STOP;
        STOP:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    frameDone = (state == STOP) && fallEdge;
    frameGood = frameDone && dataBit && oddParityOk(shiftReg, parityBit);
    frameBad  = (frameDone && !frameGood) || timeoutHit;
`ifdef PS2_BREAK_FILTER_EN
    isBreak   = frameGood && (shiftReg == PS2_BREAK_CODE);
    pushEn    = frameGood && !isBreak && !dropFlag;
`else
    pushEn    = frameGood;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitCount   <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      timeoutCnt <= '0;
      frameError <= 1'b0;
    end else begin
      frameError <= frameBad;
      if (state == IDLE || fallEdge || timeoutHit) timeoutCnt <= '0;
      else                                         timeoutCnt <= timeoutCnt + TW'(1);
      if (fallEdge) begin
        case (state)
          IDLE:    bitCount <= '0;
          DATA:    begin
                     shiftReg <= {dataBit, shiftReg[7:1]};
                     bitCount <= bitCount + 3'd1;
                   end
          PARITY:  parityBit <= dataBit;
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  // A break code swallows itself and the next good byte (the released key).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         dropFlag <= 1'b0;
    else if (frameBad)  dropFlag <= 1'b0;
    else if (isBreak)   dropFlag <= 1'b1;
    else if (frameGood) dropFlag <= 1'b0;
  end
`endif

  assign overflowSet = pushEn && fifoFull && !kbd.rd_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  overflowReg <= 1'b0;
    else if (overflowSet)        overflowReg <= 1'b1;
    else if (kbd.clear_overflow) overflowReg <= 1'b0;
  end

  keyboard_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PS2_DATA_BITS)) fifo (
    .clock (clock),
    .reset (reset),
    .push  (pushEn),
    .pop   (kbd.rd_en),
    .din   (shiftReg),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount),
    .head  (fifoHead)
  );

  assign kbd.key_data    = fifoEmpty ? 8'h00 : fifoHead;
  assign kbd.key_valid   = (fifoCount != '0);
  assign kbd.overflow    = overflowReg;
  assign kbd.frame_error = frameError;
  assign fsmState        = state;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboarded bench for ps2_keyboard_receiver; honours PS2_BREAK_FILTER_EN.
module tb_ps2_keyboard_receiver;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 40;

  logic      clock = 1'b0;
  logic      reset = 1'b0;
  ps2State_t fsmState;

  ps2_keyboard_receiver_if kbd();

  ps2_keyboard_receiver #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .kbd      (kbd),
    .fsmState (fsmState)
  );

  // clock / reset
  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  int         errSeen = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    kbd.ps2_data = b;
    wait_cycles(HALF);
    kbd.ps2_clk = 1'b0;
    wait_cycles(HALF);
    kbd.ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic badPar, input logic stopBit);
    return {stopBit, (~^b) ^ badPar, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) ps2_bit(frame[i]);
    kbd.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b1), 11);
    wait_cycles(4);
  endtask

  task automatic pop_one();
    int n = 0;
    while (!kbd.key_valid && n < 20) begin
      wait_cycles(1);
      n++;
    end
    if (!kbd.key_valid) begin
      total++;
      bad++;
      $display("FAIL pop_wait: key_valid=0 required 1");
    end else begin
      kbd.rd_en = 1'b1;
      wait_cycles(1);
      kbd.rd_en = 1'b0;
      wait_cycles(1);
    end
  endtask

  // scoreboard monitor: compares every accepted pop against the expected queue
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (kbd.frame_error) errSeen++;
      if (kbd.rd_en && kbd.key_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %0h expected no byte", kbd.key_data);
        end else begin
          check("pop_data", {24'b0, kbd.key_data}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    kbd.ps2_clk        = 1'b1;
    kbd.ps2_data       = 1'b1;
    kbd.rd_en          = 1'b0;
    kbd.clear_overflow = 1'b0;
    wait_cycles(3);
    check("rst_key_data", {24'b0, kbd.key_data}, 32'h0);
    check("rst_key_valid", {31'b0, kbd.key_valid}, 32'h0);
    check("rst_overflow", {31'b0, kbd.overflow}, 32'h0);
    check("rst_frame_error", {31'b0, kbd.frame_error}, 32'h0);
    check("rst_fsm", {30'b0, fsmState}, {30'b0, IDLE});
    reset = 1'b1;
    wait_cycles(5);

    // 0x1C with latency check around the stop edge
    exp_q.push_back(8'h1C);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 10);
    kbd.ps2_data = 1'b1;
    wait_cycles(HALF);
    kbd.ps2_clk = 1'b0;
    wait_cycles(2);
    check("latency_before", {31'b0, kbd.key_valid}, 32'h0);
    wait_cycles(1);
    check("latency_valid", {31'b0, kbd.key_valid}, 32'h1);
    check("latency_data", {24'b0, kbd.key_data}, 32'h1C);
    wait_cycles(HALF - 3);
    kbd.ps2_clk = 1'b1;
    wait_cycles(4);
    pop_one();
    check("empty_valid", {31'b0, kbd.key_valid}, 32'h0);
    check("empty_data", {24'b0, kbd.key_data}, 32'h0);

    // rd_en while empty is ignored
    kbd.rd_en = 1'b1;
    wait_cycles(1);
    kbd.rd_en = 1'b0;
    wait_cycles(1);
    check("pop_empty_valid", {31'b0, kbd.key_valid}, 32'h0);

    // parity error, then stop-bit error, then a good frame
    e0 = errSeen;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    wait_cycles(4);
    check("parity_err_pulses", errSeen - e0, 32'd1);
    check("parity_err_valid", {31'b0, kbd.key_valid}, 32'h0);
    e0 = errSeen;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
    wait_cycles(4);
    check("stop_err_pulses", errSeen - e0, 32'd1);
    check("stop_err_valid", {31'b0, kbd.key_valid}, 32'h0);
    exp_q.push_back(8'h32);
    send_frame(8'h32);
    pop_one();

    // overflow: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(i * 8'h11);
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
      send_frame(b);
      if (i == 4) check("overflow_at_4", {31'b0, kbd.overflow}, 32'h0);
    end
    check("overflow_at_5", {31'b0, kbd.overflow}, 32'h1);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_one();
    check("overflow_drained_valid", {31'b0, kbd.key_valid}, 32'h0);
    check("overflow_sticky", {31'b0, kbd.overflow}, 32'h1);
    kbd.clear_overflow = 1'b1;
    wait_cycles(1);
    kbd.clear_overflow = 1'b0;
    wait_cycles(1);
    check("overflow_cleared", {31'b0, kbd.overflow}, 32'h0);

    // timeout after start bit plus five data bits
    e0 = errSeen;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 6);
    check("timeout_in_data", {30'b0, fsmState}, {30'b0, DATA});
    wait_cycles(TIMEOUT_CYCLES + 20);
    check("timeout_err_pulses", errSeen - e0, 32'd1);
    check("timeout_fsm_idle", {30'b0, fsmState}, {30'b0, IDLE});
    check("timeout_valid", {31'b0, kbd.key_valid}, 32'h0);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C);
    pop_one();

    // break code sequence
`ifdef PS2_BREAK_FILTER_EN
    exp_q.push_back(8'h1B);
`else
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h1B);
`endif
    send_frame(8'hF0);
    send_frame(8'h1C);
    send_frame(8'h1B);
`ifdef PS2_BREAK_FILTER_EN
    pop_one();
`else
    for (int i = 0; i < 3; i++) pop_one();
`endif
    check("break_drained_valid", {31'b0, kbd.key_valid}, 32'h0);

    // asynchronous reset mid-frame with one byte buffered
    send_frame(8'h5A);
    check("pre_reset_valid", {31'b0, kbd.key_valid}, 32'h1);
    send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 5);
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, kbd.key_valid}, 32'h0);
    check("async_rst_data", {24'b0, kbd.key_data}, 32'h0);
    check("async_rst_overflow", {31'b0, kbd.overflow}, 32'h0);
    check("async_rst_frame_error", {31'b0, kbd.frame_error}, 32'h0);
    check("async_rst_fsm", {30'b0, fsmState}, {30'b0, IDLE});
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(5);
    exp_q.push_back(8'h2B);
    send_frame(8'h2B);
    pop_one();

    wait_cycles(5);
    check("exp_q_empty", exp_q.size(), 32'd0);
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
